packet_buffer_read_sequencer: RTL
=================================

# packet_buffer_read_sequencer

Downstream stage of the packet buffer write controller. It drains the per-lane packet FIFOs back into a single AXI-stream output in the original packet arrival order. The write controller reports which lane each new packet was steered to. This block queues those lane indices and locks onto one lane for the whole packet, until its last beat, before moving to the next queued lane.

## Interface
Parameters:
- NUM_LANES, 4, number of lane FIFOs.
- AXI_WIDTH, 64, beat data width in bits.
- LANE_SELECT_IDX_WIDTH, 2, width of a lane index; must be ≥ $clog2(NUM_LANES).
- ORDER_DEPTH, 16, entries in the lane-order queue; power of two.

Ports (`<` = input, `>` = output):
- clk_i < 1: single clock.
- rst_ni < 1: reset, asynchronous assert, active-low.
- order_push_i < 1: one-cycle pulse on the first accepted beat of each packet.
- order_lane_i < LANE_SELECT_IDX_WIDTH: lane index of that packet.
- order_full_o > 1: queue holds ORDER_DEPTH entries; upstream must not start a new packet.
- order_overflow_o > 1: sticky; set by a push while full; cleared only by reset.
- lane_data_i < AXI_WIDTH × NUM_LANES (unpacked array): FIFO read data per lane.
- lane_valid_i < 1 × NUM_LANES: FIFO non-empty per lane.
- lane_last_i < 1 × NUM_LANES: beat is the packet's last.
- lane_ready_o > 1 × NUM_LANES: pop strobe per lane; at most one high per cycle.
- m_data_o > AXI_WIDTH: output beat.
- m_valid_o > 1: output valid.
- m_last_o > 1: output last.
- m_ready_i < 1: downstream ready.

## Operation
- **Order queue:** circular buffer with ORDER_DEPTH entries of LANE_SELECT_IDX_WIDTH bits.
  - Pointers are $clog2(ORDER_DEPTH) bits and wrap naturally.
  - Count is $clog2(ORDER_DEPTH)+1 bits.
  - Push when order_push_i && !order_full_o. Pop on the handshake of a packet's last beat.
  - Simultaneous push and pop leave the count unchanged; both pointers advance.
  - A push while full is dropped and sets order_overflow_o. The queue is unchanged.
- **FSM, IDLE:** no lane locked; all lane_ready_o low.
  - If count>0: latch cur_lane = head entry and go to STREAM.
- **FSM, STREAM:** lane_ready_o[cur_lane] = lane_valid_i[cur_lane] && out_can_load.
  - out_can_load = !m_valid_o || m_ready_i.
  - Each lane handshake loads data and last into the output register.
- **End of packet:** on a lane handshake with lane_last_i[cur_lane]=1, pop the queue.
  - If count>1 (before the pop): load cur_lane from the next entry and stay in STREAM. No bubble.
  - Otherwise: go to IDLE.
  - A push in the same cycle as a pop at count==1 is serviced from IDLE on the next cycle.
- **Lane isolation:** lanes other than cur_lane are never popped, whatever their valid state.
- **Output register:** m_valid_o is set on load, cleared on m_valid_o && m_ready_i with no new load, and held otherwise. Data is stable while m_valid_o && !m_ready_i.
- **Reset values** (asynchronous, while rst_ni=0):
  - m_valid_o=0, m_last_o=0, m_data_o=0.
  - lane_ready_o all 0, order_full_o=0, order_overflow_o=0.
  - Queue empty, FSM=IDLE, cur_lane=0.
- **Reset mid-packet:** the partially forwarded packet is abandoned. No beat is emitted after rst_ni deasserts until a new push.

## Timing
- Push at edge t → entry visible at t+1 → IDLE latches the lane at edge t+1 → lane_ready_o can rise in cycle t+1→t+2 → m_valid_o at t+2 at the earliest.
- Steady state: one beat per cycle with m_ready_i=1, including back-to-back packets on different lanes.
- lane_ready_o is combinational from FSM state, cur_lane, lane_valid_i, m_valid_o and m_ready_i. There are no combinational paths from m_ready_i to m_valid_o.
- order_full_o is registered-derived (count==ORDER_DEPTH) and valid in the same cycle as the count.

## Structure
- packet_buffer_pkg holds:
  - the FSM state typedef (SEQ_IDLE, SEQ_STREAM);
  - a lane-beat struct {data, last}.
- Sub-module: packet_buffer_order_fifo. It is the generic circular index queue, with push/pop/full/empty/count, and is reusable elsewhere.
- The FSM, lane mux and output register live in the top module.

## Test plan
- **Reset:** hold rst_ni=0 for 3 cycles with lane_valid_i all 1 → all outputs 0, no lane_ready_o.
- **Single packet:** push lane 1; lane 1 presents 3 beats (0xA1..0xA3, last on 3rd); m_ready_i=1 → m_valid_o first at push+2; beats in order; m_last_o on 0xA3; queue empty after.
- **Ordering:** push lanes 2, 0, 1 on consecutive cycles; all lanes hold 2-beat packets and are valid from the start → output order is lane 2, lane 0, lane 1; no idle cycle between packets.
- **Backpressure:** during a 4-beat packet, m_ready_i toggles 1,0,0,1 → m_data_o is held stable while stalled; no beat is lost or duplicated; lane_ready_o is low during stalls.
- **Full/overflow:** 16 pushes with no lane data → order_full_o=1; a 17th push sets order_overflow_o; draining one packet clears order_full_o; the overflow bit stays set.
- **Reset mid-packet:** assert rst_ni low after beat 2 of 5 → m_valid_o=0 immediately; after release, no output until a new push.

Source files
------------

// File: rtl/packet_buffer_pkg.sv
// Shared types for the packet buffer read path: sequencer FSM states and the
// registered lane beat that feeds the AXI-stream output.
package packet_buffer_pkg;

  localparam int unsigned PB_BEAT_WIDTH = 64;

  typedef enum logic [0:0] {
    SEQ_IDLE   = 1'b0,
    SEQ_STREAM = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [PB_BEAT_WIDTH-1:0] data;
    logic                     last;
  } lane_beat_t;

endpackage

// File: rtl/packet_buffer_order_fifo.sv
// Generic circular index queue. Exposes the head entry and the entry behind it
// so a consumer can advance without a bubble. A push while full is dropped and flagged.
module packet_buffer_order_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] next_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_next_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == CW'(0));
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign push_ok     = push_i && !full_o;
  assign pop_ok      = pop_i && !empty_o;
  assign rd_next_ptr = rd_ptr_q + AW'(1);
  assign head_o      = mem_q[rd_ptr_q];
  assign next_o      = mem_q[rd_next_ptr];

  // Storage, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_next_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push_i && full_o) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_buffer_read_sequencer.sv
// Drains per-lane packet FIFOs into one AXI-stream in arrival order, locking onto
// the queued lane for a whole packet and chaining to the next lane without a bubble.
module packet_buffer_read_sequencer
  import packet_buffer_pkg::*;
#(
  parameter int unsigned NUM_LANES             = 4,
  parameter int unsigned AXI_WIDTH             = 64,
  parameter int unsigned LANE_SELECT_IDX_WIDTH = 2,
  parameter int unsigned ORDER_DEPTH           = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             order_push_i,
  input  logic [LANE_SELECT_IDX_WIDTH-1:0] order_lane_i,
  output logic                             order_full_o,
  output logic                             order_overflow_o,
  input  logic [AXI_WIDTH-1:0]             lane_data_i [NUM_LANES],
  input  logic [NUM_LANES-1:0]             lane_valid_i,
  input  logic [NUM_LANES-1:0]             lane_last_i,
  output logic [NUM_LANES-1:0]             lane_ready_o,
  output logic [AXI_WIDTH-1:0]             m_data_o,
  output logic                             m_valid_o,
  output logic                             m_last_o,
  input  logic                             m_ready_i
);

  localparam int unsigned CW = $clog2(ORDER_DEPTH) + 1;

  seq_state_e                       state_q;
  logic [LANE_SELECT_IDX_WIDTH-1:0] cur_lane_q;
  logic [LANE_SELECT_IDX_WIDTH-1:0] head_lane;
  logic [LANE_SELECT_IDX_WIDTH-1:0] next_lane;
  logic [CW-1:0]                    order_count;
  logic                             order_empty;
  logic                             m_valid_q;
  lane_beat_t                       beat_q;
  lane_beat_t                       beat_d;
  logic                             out_can_load;
  logic                             lane_hs;
  logic                             lane_eop;
  logic                             more_queued;

  packet_buffer_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .WIDTH (LANE_SELECT_IDX_WIDTH)
  ) u_order_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (order_push_i),
    .data_i     (order_lane_i),
    .pop_i      (lane_eop),
    .head_o     (head_lane),
    .next_o     (next_lane),
    .full_o     (order_full_o),
    .empty_o    (order_empty),
    .count_o    (order_count),
    .overflow_o (order_overflow_o)
  );

  assign out_can_load = !m_valid_q || m_ready_i;
  assign lane_eop     = lane_hs && lane_last_i[cur_lane_q];
  assign more_queued  = (order_count > CW'(1));
  assign m_valid_o    = m_valid_q;
  assign m_data_o     = beat_q.data[AXI_WIDTH-1:0];
  assign m_last_o     = beat_q.last;

  // Pop strobe only for the locked lane; other lanes are never touched.
  always_comb begin
    lane_ready_o = '0;
    lane_hs      = 1'b0;
    if (state_q == SEQ_STREAM) begin
      lane_hs                  = lane_valid_i[cur_lane_q] && out_can_load;
      lane_ready_o[cur_lane_q] = lane_hs;
    end else begin
      lane_hs = 1'b0;
    end
  end

  // Next output beat: captured from the locked lane on its handshake.
  always_comb begin
    beat_d = beat_q;
    if (lane_hs) begin
      beat_d                      = '0;
      beat_d.data[AXI_WIDTH-1:0]  = lane_data_i[cur_lane_q];
      beat_d.last                 = lane_last_i[cur_lane_q];
    end else begin
      beat_d = beat_q;
    end
  end

  // Sequencer FSM and output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SEQ_IDLE;
      cur_lane_q <= '0;
      m_valid_q  <= 1'b0;
      beat_q     <= '0;
    end else begin
      beat_q <= beat_d;
      if (lane_hs) begin
        m_valid_q <= 1'b1;
      end else if (m_ready_i) begin
        m_valid_q <= 1'b0;
      end else begin
        m_valid_q <= m_valid_q;
      end
      case (state_q)
        SEQ_IDLE: begin
          if (!order_empty) begin
            cur_lane_q <= head_lane;
            state_q    <= SEQ_STREAM;
          end
        end
        SEQ_STREAM: begin
          // A pending next entry is picked up in the same edge as the last beat.
          if (lane_eop) begin
            if (more_queued) begin
              cur_lane_q <= next_lane;
            end else begin
              state_q <= SEQ_IDLE;
            end
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

endmodule
